// File: rtl/fpu_cvt_arbiter.sv
// fpu_cvt_arbiter: shares one external combinational INT32->F32 converter
// between REQ_NUM requesters. Round-robin issue (one per cycle), LATENCY-deep
// result pipeline tagged with the owner ID, whole-pipeline stall on backpressure.
// Optional macro FPU_CVT_ARB_PERF_EN adds PERF_ISSUE / PERF_STALL counters.
module fpu_cvt_arbiter #(
    parameter int REQ_NUM = 4,
    parameter int LATENCY = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [REQ_NUM-1:0]     REQ_VALID,
    output logic [REQ_NUM-1:0]     REQ_READY,
    input  logic [32*REQ_NUM-1:0]  REQ_DATA,
    output logic [31:0]            CVT_A,
    input  logic [31:0]            CVT_O,
    output logic [REQ_NUM-1:0]     RES_VALID,
    input  logic [REQ_NUM-1:0]     RES_READY,
    output logic [31:0]            RES_DATA,
    output logic                   BUSY
`ifdef FPU_CVT_ARB_PERF_EN
    ,
    output logic [31:0]            PERF_ISSUE,
    output logic [31:0]            PERF_STALL
`endif
);

    localparam int IDW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int LST = LATENCY - 1;

    // Stage 0 is S1 (loaded on accept), stage LST drives the result outputs.
    logic [LATENCY-1:0]          r_vld;
    logic [LATENCY-1:0][IDW-1:0] r_id;
    logic [LATENCY-1:0][31:0]    r_data;
    logic [IDW-1:0]              r_ptr;

    logic                        w_adv;
    logic                        w_res_rdy;
    logic                        w_found;
    logic                        w_grant;
    logic [IDW-1:0]              w_win;
    logic [IDW-1:0]              w_ptr_nxt;

    // Advance: last stage empty or its owner is taking the result this cycle.
    always_comb begin
        w_res_rdy = 1'b0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (r_id[LST] == IDW'(k) && RES_READY[k])
                w_res_rdy = 1'b1;
        end
        w_adv = !r_vld[LST] || w_res_rdy;
    end

    // Round-robin search starting at the pointer, wrapping at REQ_NUM-1.
    always_comb begin
        logic [IDW:0] sum;
        w_found = 1'b0;
        w_win   = '0;
        sum     = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(REQ_NUM))
                sum = sum - (IDW+1)'(REQ_NUM);
            if (!w_found && REQ_VALID[sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = sum[IDW-1:0];
            end
        end
        w_grant = w_found && w_adv;
    end

    // Grant fan-out, converter operand mux and result routing.
    always_comb begin
        REQ_READY = '0;
        RES_VALID = '0;
        CVT_A     = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (w_grant && w_win == IDW'(k)) begin
                REQ_READY[k] = 1'b1;
                CVT_A        = REQ_DATA[32*k +: 32];
            end
            if (r_vld[LST] && r_id[LST] == IDW'(k))
                RES_VALID[k] = 1'b1;
        end
        RES_DATA = r_data[LST];
        BUSY     = |r_vld;
    end

    // Pointer moves just past the winner so every waiter is reached in turn.
    always_comb begin
        if (w_win == IDW'(REQ_NUM - 1))
            w_ptr_nxt = '0;
        else
            w_ptr_nxt = w_win + 1'b1;
    end

    // Result pipeline: shifts as a whole on advance, holds entirely otherwise.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_vld  <= '0;
            r_id   <= '0;
            r_data <= '0;
        end else if (w_adv) begin
            r_vld[0]  <= w_grant;
            r_id[0]   <= w_grant ? w_win : '0;
            r_data[0] <= w_grant ? CVT_O : 32'd0;
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_id[s]   <= r_id[s-1];
                r_data[s] <= r_data[s-1];
            end
        end
    end

    // Round-robin pointer update on each accepted request.
    always_ff @(posedge CLK) begin
        if (!nRST)
            r_ptr <= '0;
        else if (w_grant)
            r_ptr <= w_ptr_nxt;
    end

`ifdef FPU_CVT_ARB_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;

    // Issue count and cycles where someone wanted to issue but the pipe was held.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_grant)
                r_perf_issue <= r_perf_issue + 32'd1;
            if ((|REQ_VALID) && !w_adv)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign PERF_ISSUE = r_perf_issue;
    assign PERF_STALL = r_perf_stall;
`endif

endmodule
